uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
Parametrised next-generation UART receiver for the serial peripheral path. It oversamples the line with an external tick and samples each bit at mid-period. Data width, oversample ratio and stop-bit count are configurable. It rejects false starts, reports framing and parity errors, and presents each received word on a valid/ready output with overrun detection.

Parameters:
DATA_BITS, 8, data bits per frame (5..9), sent LSB first
OVERSAMPLE, 16, baud_tick pulses per bit period (even, 4..64)
STOP_BITS, 1, stop bits checked (1 or 2)
PARITY_ODD, 0, parity sense when parity is compiled in (0 = even, 1 = odd)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
baud_tick  in  1  one-clk pulse at OVERSAMPLE x baud rate
data_in  in  1  serial line, idle high
data_out  out  DATA_BITS  received word, stable while rx_valid=1
rx_valid  out  1  word available
rx_ready  in  1  consumer accepts the word when rx_valid&&rx_ready
frame_err  out  1  stop bit sampled 0 for the held word
parity_err  out  1  parity mismatch for the held word (0 when parity is compiled out)
overrun  out  1  one-clk pulse: a completed frame was dropped

Behaviour:
- Reset: asynchronous and active-high. All flops clear immediately. Synchroniser flops go to 1. State goes to IDLE; tick_cnt=0; bit_idx=0. Outputs data_out=0, rx_valid=0, frame_err=0, parity_err=0, overrun=0.
- Reset mid-frame abandons the frame and discards any held word. Reception resumes only after rst deasserts and a new falling edge arrives.
- Input path: 2-flop synchroniser on data_in, giving rx. All decisions use rx.
- tick_cnt has width clog2(OVERSAMPLE). It advances only on baud_tick.
- State machine (IDLE, START, DATA, PARITY, STOP):
  - IDLE: rx==0 -> START, tick_cnt=0.
  - START: on the tick where tick_cnt reaches OVERSAMPLE/2-1, re-check rx. If rx==1 it is a false start -> IDLE with no output. If rx==0 -> DATA, tick_cnt=0, bit_idx=0.
  - DATA: on the tick where tick_cnt reaches OVERSAMPLE-1 (bit centre), shift rx into shreg[bit_idx] and reset tick_cnt. When bit_idx==DATA_BITS-1 -> PARITY if compiled in, else STOP; otherwise bit_idx+1.
  - PARITY: sample at centre, compute the error flag, then -> STOP.
  - STOP: sample at each stop-bit centre. Any stop sample of 0 sets frame_err_pend. After the STOP_BITS-th sample, complete the frame -> IDLE. Return to IDLE happens at the centre of the last stop bit, so back-to-back frames are accepted.
- Frame completion, on the clk after the final stop sample:
  - If rx_valid==0 or (rx_valid&&rx_ready) in that same cycle: load data_out, frame_err and parity_err, and set rx_valid=1.
  - Otherwise: keep the old word and flags, and pulse overrun for 1 clk.
- Handshake: rx_valid&&rx_ready clears rx_valid next clk unless a new frame is loaded in that same cycle. data_out and the flags hold until then.
- Frames with frame_err=1 are still delivered. The flag tells the consumer.
- baud_tick is ignored while in IDLE. Edge detection runs every clk.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined: the PARITY state exists. Parity = XOR(data bits) XOR rx_parity XOR PARITY_ODD; nonzero sets parity_err for the word.
- Undefined: no PARITY state, no parity logic, and parity_err is tied to 0.

Test Plan:
- DATA_BITS=8, OVERSAMPLE=16, baud_tick every clk; send 0xA5 with one stop bit -> rx_valid=1 with data_out=0xA5, frame_err=0; rx_ready=1 clears rx_valid next clk.
- Drive data_in low for 5 ticks, then high -> no rx_valid; FSM back in IDLE; a following 0x3C frame is received correctly.
- Send 0x55 with stop bit=0 -> rx_valid=1, data_out=0x55, frame_err=1; the next clean frame gives frame_err=0.
- Send 0x11 then 0x22 with rx_ready=0 -> overrun pulses exactly 1 clk; data_out stays 0x11; after a handshake rx_valid=0.
- With UART_RX_PARITY_EN and PARITY_ODD=0: 0x03 with parity bit 1 -> parity_err=1; with parity bit 0 -> parity_err=0.
- Assert rst halfway through the DATA bits of 0xFF -> outputs clear immediately, no rx_valid. DATA_BITS=5, STOP_BITS=2: send 0x1B -> data_out=0x1B.

Source files
------------

// File: rtl/uart_rx_param_if.sv
// uart_rx_param_if: receive-side word handshake between the UART receiver and its consumer
// Signals: data_out (received word), rx_valid (word held), rx_ready (consumer accepts),
//          frame_err / parity_err (flags of the held word), overrun (one-clk dropped-frame pulse)
// Modports: master = receiver, slave = consumer
interface uart_rx_param_if #(parameter int DATA_BITS = 8);
    logic [DATA_BITS-1:0] data_out;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;
    modport master (output data_out, rx_valid, frame_err, parity_err, overrun, input rx_ready);
    modport slave (input data_out, rx_valid, frame_err, parity_err, overrun, output rx_ready);
endinterface

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with false-start rejection, framing/parity checks and valid/ready output
// Ports: clk, rst (asynchronous, active-high), baud_tick (one-clk strobe at OVERSAMPLE x baud),
//        data_in (serial line, idle high), rx_if (master side: data_out, rx_valid, frame_err,
//        parity_err, overrun out; rx_ready in)
// Build option: define UART_RX_PARITY_EN to receive and check a parity bit after the data bits.
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            baud_tick,
    input  logic            data_in,
    uart_rx_param_if.master rx_if
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 4 || OVERSAMPLE > 64 || OVERSAMPLE % 2 != 0 ||
        STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
        $error("uart_rx_param: parameter out of range");
    end
`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
    state_t               state, state_n;
    logic                 sync1, rx;
    logic [TW-1:0]        tick_cnt, tick_n;
    logic [BW-1:0]        bit_idx, bit_n;
    logic                 stop_cnt, stop_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 fe_pend, fe_n;
    logic                 done, done_n;
    logic                 mid, ctr;
`ifdef UART_RX_PARITY_EN
    logic                 pe_pend, pe_n;
`endif
    assign mid = tick_cnt == TW'(OVERSAMPLE / 2 - 1);
    assign ctr = tick_cnt == TW'(OVERSAMPLE - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= 1'b1;
            rx       <= 1'b1;
            state    <= IDLE;
            tick_cnt <= '0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            shreg    <= '0;
            fe_pend  <= 1'b0;
            done     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pe_pend  <= 1'b0;
`endif
        end else begin
            sync1    <= data_in;
            rx       <= sync1;
            state    <= state_n;
            tick_cnt <= tick_n;
            bit_idx  <= bit_n;
            stop_cnt <= stop_n;
            shreg    <= shreg_n;
            fe_pend  <= fe_n;
            done     <= done_n;
`ifdef UART_RX_PARITY_EN
            pe_pend  <= pe_n;
`endif
        end
    end
    // Edge detection in IDLE runs every clk; all later steps advance only on baud_tick.
    always_comb begin
        state_n = state;
        tick_n  = tick_cnt;
        bit_n   = bit_idx;
        stop_n  = stop_cnt;
        shreg_n = shreg;
        fe_n    = fe_pend;
        done_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
        pe_n    = pe_pend;
`endif
        if (state == IDLE) begin
            if (!rx) begin
                state_n = START;
                tick_n  = '0;
            end
        end else if (baud_tick) begin
            tick_n = tick_cnt + 1'b1;
            case (state)
                START: if (mid) begin
                    tick_n  = '0;
                    bit_n   = '0;
                    stop_n  = 1'b0;
                    fe_n    = 1'b0;
                    state_n = rx ? IDLE : DATA;
                end
                DATA: if (ctr) begin
                    tick_n           = '0;
                    shreg_n[bit_idx] = rx;
                    bit_n            = bit_idx + 1'b1;
                    if (bit_idx == BW'(DATA_BITS - 1)) begin
                        bit_n = '0;
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: if (ctr) begin
                    tick_n  = '0;
                    pe_n    = ^shreg ^ rx ^ (PARITY_ODD != 0);
                    state_n = STOP;
                end
`endif
                // Leaving at the centre of the last stop bit leaves half a bit to catch the next start edge.
                STOP: if (ctr) begin
                    tick_n = '0;
                    fe_n   = fe_pend | ~rx;
                    stop_n = stop_cnt + 1'b1;
                    if (stop_cnt == 1'(STOP_BITS - 1)) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
    // A finished frame loads only if the holding slot is empty or being emptied this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_if.data_out  <= '0;
            rx_if.rx_valid  <= 1'b0;
            rx_if.frame_err <= 1'b0;
            rx_if.overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            rx_if.parity_err <= 1'b0;
`endif
        end else begin
            rx_if.overrun <= 1'b0;
            if (done && (!rx_if.rx_valid || rx_if.rx_ready)) begin
                rx_if.data_out  <= shreg;
                rx_if.frame_err <= fe_pend;
                rx_if.rx_valid  <= 1'b1;
`ifdef UART_RX_PARITY_EN
                rx_if.parity_err <= pe_pend;
`endif
            end else if (done) begin
                rx_if.overrun <= 1'b1;
            end else if (rx_if.rx_valid && rx_if.rx_ready) begin
                rx_if.rx_valid <= 1'b0;
            end
        end
    end
`ifndef UART_RX_PARITY_EN
    assign rx_if.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: randomized and directed checks of uart_rx_param against a frame-level reference model
module tb_uart_rx_param;
    localparam int OS   = 16;
    localparam int PODD = 0;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic baud_tick = 1'b1;
    logic data_in = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    int   ov_cnt = 0;
    logic [10:0] obs[$];
    logic [10:0] exp_q[$];
    uart_rx_param_if #(.DATA_BITS(8)) ia ();
    uart_rx_param_if #(.DATA_BITS(5)) ib ();
    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .STOP_BITS(1), .PARITY_ODD(PODD)) dut_a (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .data_in(data_in), .rx_if(ia));
    uart_rx_param #(.DATA_BITS(5), .OVERSAMPLE(OS), .STOP_BITS(2), .PARITY_ODD(PODD)) dut_b (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .data_in(data_in), .rx_if(ib));
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (ia.overrun) ov_cnt++;
        if (ia.rx_valid && ia.rx_ready) obs.push_back({ia.frame_err, ia.parity_err, 1'b0, ia.data_out});
    end
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
    endtask
    // Reference: parity bit that makes the frame clean for the configured sense.
    function automatic logic good_par(input logic [8:0] d, input int nb);
        logic p = (PODD != 0);
        for (int i = 0; i < nb; i++) p ^= d[i];
        return p;
    endfunction
    // Reference: parity_err the receiver must report for a given transmitted parity bit.
    function automatic logic exp_pe(input logic [8:0] d, input int nb, input logic par);
`ifdef UART_RX_PARITY_EN
        return par ^ good_par(d, nb);
`else
        return (nb < 0) & par;
`endif
    endfunction
    task automatic send_frame(input logic [8:0] d, input int nb, input logic par, input int ns, input logic [1:0] st);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < nb; i++) bits.push_back(d[i]);
`ifdef UART_RX_PARITY_EN
        bits.push_back(par);
`endif
        for (int i = 0; i < ns; i++) bits.push_back(st[i]);
        foreach (bits[i]) begin
            data_in = bits[i];
            tick(OS);
        end
    endtask
    task automatic handshake_a();
        ia.rx_ready = 1'b1;
        tick(1);
        ia.rx_ready = 1'b0;
    endtask
    task automatic test_reset();
        tick(3);
        n_tests++; if (ia.data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", ia.data_out); end
        n_tests++; if (ia.rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", ia.rx_valid); end
        n_tests++; if (ia.frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b want 0", ia.frame_err); end
        n_tests++; if (ia.parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b want 0", ia.parity_err); end
        n_tests++; if (ia.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b want 0", ia.overrun); end
        n_tests++; if (ib.rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid_b: got %b want 0", ib.rx_valid); end
        rst = 1'b0;
        tick(2);
    endtask
    task automatic test_basic();
        send_frame(9'h0A5, 8, good_par(9'h0A5, 8), 1, 2'b11);
        tick(2);
        n_tests++; if (ia.rx_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", ia.rx_valid); end
        n_tests++; if (ia.data_out !== 8'hA5) begin n_fail++; $display("FAIL basic_data: got %h want a5", ia.data_out); end
        n_tests++; if (ia.frame_err !== 1'b0) begin n_fail++; $display("FAIL basic_ferr: got %b want 0", ia.frame_err); end
        n_tests++; if (ia.parity_err !== 1'b0) begin n_fail++; $display("FAIL basic_perr: got %b want 0", ia.parity_err); end
        handshake_a();
        n_tests++; if (ia.rx_valid !== 1'b0) begin n_fail++; $display("FAIL basic_clear: got %b want 0", ia.rx_valid); end
    endtask
    task automatic test_false_start();
        data_in = 1'b0;
        tick(5);
        data_in = 1'b1;
        tick(3 * OS);
        n_tests++; if (ia.rx_valid !== 1'b0) begin n_fail++; $display("FAIL false_start_valid: got %b want 0", ia.rx_valid); end
        send_frame(9'h03C, 8, good_par(9'h03C, 8), 1, 2'b11);
        tick(2);
        n_tests++; if (ia.rx_valid !== 1'b1) begin n_fail++; $display("FAIL after_false_valid: got %b want 1", ia.rx_valid); end
        n_tests++; if (ia.data_out !== 8'h3C) begin n_fail++; $display("FAIL after_false_data: got %h want 3c", ia.data_out); end
        handshake_a();
    endtask
    task automatic test_frame_err();
        send_frame(9'h055, 8, good_par(9'h055, 8), 1, 2'b00);
        data_in = 1'b1;
        tick(2);
        n_tests++; if (ia.rx_valid !== 1'b1) begin n_fail++; $display("FAIL ferr_valid: got %b want 1", ia.rx_valid); end
        n_tests++; if (ia.data_out !== 8'h55) begin n_fail++; $display("FAIL ferr_data: got %h want 55", ia.data_out); end
        n_tests++; if (ia.frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_flag: got %b want 1", ia.frame_err); end
        handshake_a();
        tick(OS);
        send_frame(9'h096, 8, good_par(9'h096, 8), 1, 2'b11);
        tick(2);
        n_tests++; if (ia.frame_err !== 1'b0) begin n_fail++; $display("FAIL ferr_clean: got %b want 0", ia.frame_err); end
        n_tests++; if (ia.data_out !== 8'h96) begin n_fail++; $display("FAIL ferr_clean_data: got %h want 96", ia.data_out); end
        handshake_a();
    endtask
    task automatic test_overrun();
        ov_cnt = 0;
        send_frame(9'h011, 8, good_par(9'h011, 8), 1, 2'b11);
        send_frame(9'h022, 8, good_par(9'h022, 8), 1, 2'b11);
        tick(4);
        n_tests++; if (ov_cnt !== 1) begin n_fail++; $display("FAIL overrun_pulses: got %0d want 1", ov_cnt); end
        n_tests++; if (ia.data_out !== 8'h11) begin n_fail++; $display("FAIL overrun_data: got %h want 11", ia.data_out); end
        n_tests++; if (ia.rx_valid !== 1'b1) begin n_fail++; $display("FAIL overrun_valid: got %b want 1", ia.rx_valid); end
        handshake_a();
        n_tests++; if (ia.rx_valid !== 1'b0) begin n_fail++; $display("FAIL overrun_clear: got %b want 0", ia.rx_valid); end
    endtask
`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        send_frame(9'h003, 8, 1'b1, 1, 2'b11);
        tick(2);
        n_tests++; if (ia.parity_err !== 1'b1) begin n_fail++; $display("FAIL parity_bad: got %b want 1", ia.parity_err); end
        handshake_a();
        send_frame(9'h003, 8, 1'b0, 1, 2'b11);
        tick(2);
        n_tests++; if (ia.parity_err !== 1'b0) begin n_fail++; $display("FAIL parity_good: got %b want 0", ia.parity_err); end
        handshake_a();
    endtask
`endif
    task automatic test_reset_mid();
        send_frame(9'h05A, 8, good_par(9'h05A, 8), 1, 2'b11);
        tick(2);
        data_in = 1'b0;
        tick(OS);
        data_in = 1'b1;
        tick(4 * OS + 3);
        #2 rst = 1'b1;
        #1;
        n_tests++; if (ia.rx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b want 0", ia.rx_valid); end
        n_tests++; if (ia.data_out !== 8'h00) begin n_fail++; $display("FAIL rst_mid_data: got %h want 00", ia.data_out); end
        tick(1);
        rst = 1'b0;
        tick(8 * OS);
        n_tests++; if (ia.rx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_after: got %b want 0", ia.rx_valid); end
    endtask
    task automatic test_back_to_back();
        logic [8:0] d;
        logic       bad, par, pe;
        ia.rx_ready = 1'b1;
        tick(2);
        obs.delete();
        exp_q.delete();
        ov_cnt = 0;
        for (int k = 0; k < 24; k++) begin
            d   = 9'($urandom_range(0, 255));
            bad = $urandom_range(0, 3) == 0;
            par = 1'($urandom_range(0, 1));
            pe  = exp_pe(d, 8, par);
            send_frame(d, 8, par, 1, {1'b1, ~bad});
            exp_q.push_back({bad, pe, d});
            if (bad || $urandom_range(0, 1) == 1) begin
                data_in = 1'b1;
                tick($urandom_range(OS, 3 * OS));
            end
        end
        data_in = 1'b1;
        tick(2 * OS);
        n_tests++; if (obs.size() !== exp_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", obs.size(), exp_q.size()); end
        n_tests++; if (ov_cnt !== 0) begin n_fail++; $display("FAIL b2b_overrun: got %0d want 0", ov_cnt); end
        for (int k = 0; k < exp_q.size() && k < obs.size(); k++) begin
            n_tests++;
            if (obs[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL b2b_word%0d: got fe=%b pe=%b data=%h want fe=%b pe=%b data=%h", k,
                         obs[k][10], obs[k][9], obs[k][7:0], exp_q[k][10], exp_q[k][9], exp_q[k][7:0]);
            end
        end
        ia.rx_ready = 1'b0;
    endtask
    task automatic test_5bit_2stop();
        do_reset();
        ib.rx_ready = 1'b0;
        send_frame(9'h01B, 5, good_par(9'h01B, 5), 2, 2'b11);
        tick(2);
        n_tests++; if (ib.rx_valid !== 1'b1) begin n_fail++; $display("FAIL b5_valid: got %b want 1", ib.rx_valid); end
        n_tests++; if (ib.data_out !== 5'h1B) begin n_fail++; $display("FAIL b5_data: got %h want 1b", ib.data_out); end
        n_tests++; if (ib.frame_err !== 1'b0) begin n_fail++; $display("FAIL b5_ferr: got %b want 0", ib.frame_err); end
        ib.rx_ready = 1'b1;
        tick(1);
        ib.rx_ready = 1'b0;
        send_frame(9'h00A, 5, good_par(9'h00A, 5), 2, 2'b01);
        data_in = 1'b1;
        tick(2);
        n_tests++; if (ib.data_out !== 5'h0A) begin n_fail++; $display("FAIL b5_stop2_data: got %h want 0a", ib.data_out); end
        n_tests++; if (ib.frame_err !== 1'b1) begin n_fail++; $display("FAIL b5_stop2_ferr: got %b want 1", ib.frame_err); end
    endtask
    initial begin
        ia.rx_ready = 1'b0;
        ib.rx_ready = 1'b0;
        test_reset();
        test_basic();
        test_false_start();
        test_frame_err();
        test_overrun();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_reset_mid();
        test_back_to_back();
        test_5bit_2stop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
